// File: rtl/pc_stack_unit.sv
// pc_stack_unit: program counter with PC-relative branch and call/return.
// Calls push onto a small internal return-address stack. The unit also has
// a global hold and a configurable reset vector.
// Optional feature macro: PC_STK_ERR_EN. When it is defined, cmd_err is a
// sticky flag. It records conflicting commands, stack overflow and stack
// underflow. When it is undefined, cmd_err is tied low and its flop is
// removed. Illegal commands are still ignored in that build.
module pc_stack_unit #(
  parameter int              PC_W    = 16,
  parameter int              OFF_W   = 8,
  parameter int              STK_D   = 4,
  parameter logic [PC_W-1:0] RST_VEC = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pc_hold,
  input  logic             pc_inc,
  input  logic             pc_ld,
  input  logic             pc_rel,
  input  logic             pc_call,
  input  logic             pc_ret,
  input  logic [PC_W-1:0]  pc_in,
  input  logic [OFF_W-1:0] pc_off,
  output logic [PC_W-1:0]  pc_out,
  output logic             stk_empty,
  output logic             stk_full,
  output logic             cmd_err
);

  // PW indexes a stack entry. CW can also hold the value STK_D.
  localparam int PW = (STK_D > 1) ? $clog2(STK_D) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] CNT_FULL = CW'(STK_D);

  // Architectural state
  logic [PC_W-1:0] pc_q, pc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            empty_q, full_q;
  logic [PC_W-1:0] stk_q [STK_D];

  // Command decode
  logic [4:0]      cmd;
  logic            cmd_none;
  logic            cmd_one;
  logic            push_en;
  logic [PW-1:0]   push_idx;
  logic [PW-1:0]   top_idx;
  logic [CW-1:0]   cnt_m1;
  logic [PC_W-1:0] top_entry;
  logic [PC_W-1:0] pc_plus1;
  logic [PC_W-1:0] off_ext;

  assign cmd      = {pc_inc, pc_ld, pc_rel, pc_call, pc_ret};
  assign cmd_none = (cmd == 5'b00000);
  // A power of two has exactly one bit set.
  assign cmd_one  = !cmd_none && ((cmd & (cmd - 5'd1)) == 5'b00000);

  assign pc_plus1 = pc_q + {{(PC_W-1){1'b0}}, 1'b1};
  // Sign-extend the relative offset to the full PC width.
  // The addition then wraps in both directions.
  assign off_ext  = PC_W'($signed(pc_off));

  // The top-of-stack entry is read combinationally.
  // This lets a ret directly after a call return the value just pushed.
  assign cnt_m1    = cnt_q - CW'(1);
  assign top_idx   = cnt_m1[PW-1:0];
  assign push_idx  = cnt_q[PW-1:0];
  assign top_entry = stk_q[top_idx];

  // Next-state selection for PC, stack depth and push strobe
  always_comb begin
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    push_en = 1'b0;
    if (!pc_hold && cmd_one) begin
      if (pc_inc) begin
        pc_d = pc_plus1;
      end else if (pc_ld) begin
        pc_d = pc_in;
      end else if (pc_rel) begin
        pc_d = pc_q + off_ext;
      end else if (pc_call) begin
        // A call on a full stack is ignored.
        if (!full_q) begin
          push_en = 1'b1;
          pc_d    = pc_in;
          cnt_d   = cnt_q + CW'(1);
        end
      end else begin
        // This is a ret. A ret on an empty stack is ignored.
        if (!empty_q) begin
          pc_d  = top_entry;
          cnt_d = cnt_m1;
        end
      end
    end
  end

  // PC, depth and registered flags.
  // The flags are derived from the next depth, so they change with pc_out.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q    <= RST_VEC;
      cnt_q   <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      empty_q <= (cnt_d == '0);
      full_q  <= (cnt_d == CNT_FULL);
    end
  end

  // Return-address storage. It needs no reset because the depth counter
  // decides which entries are valid.
  always_ff @(posedge clk) begin
    if (push_en) begin
      stk_q[push_idx] <= pc_plus1;
    end
  end

`ifdef PC_STK_ERR_EN
  logic err_q;
  logic err_set;

  // Flag conflicting commands, overflow and underflow.
  // A held cycle is never flagged.
  assign err_set = !pc_hold &&
                   ((!cmd_none && !cmd_one) ||
                    (cmd_one && pc_call && full_q) ||
                    (cmd_one && pc_ret && empty_q));

  // Sticky error flag. Only reset clears it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      err_q <= 1'b0;
    end else if (err_set) begin
      err_q <= 1'b1;
    end
  end

  assign cmd_err = err_q;
`else
  assign cmd_err = 1'b0;
`endif

  assign pc_out    = pc_q;
  assign stk_empty = empty_q;
  assign stk_full  = full_q;

endmodule

// File: tb/tb_pc_stack_unit.sv
// Self-checking bench for pc_stack_unit.
// The driver applies one command per cycle and updates a reference model
// built on a queue. It pushes the expected outputs into a scoreboard.
// A monitor process pops the scoreboard on each falling edge and compares.
module tb_pc_stack_unit;

  localparam int          PC_W    = 16;
  localparam int          OFF_W   = 8;
  localparam int          STK_D   = 4;
  localparam logic [15:0] RST_VEC = 16'h0100;

  localparam logic [4:0] C_NONE = 5'b00000;
  localparam logic [4:0] C_INC  = 5'b10000;
  localparam logic [4:0] C_LD   = 5'b01000;
  localparam logic [4:0] C_REL  = 5'b00100;
  localparam logic [4:0] C_CALL = 5'b00010;
  localparam logic [4:0] C_RET  = 5'b00001;

  logic             clk;
  logic             reset;
  logic             pc_hold;
  logic             pc_inc, pc_ld, pc_rel, pc_call, pc_ret;
  logic [PC_W-1:0]  pc_in;
  logic [OFF_W-1:0] pc_off;
  logic [PC_W-1:0]  pc_out;
  logic             stk_empty, stk_full, cmd_err;

  pc_stack_unit #(
    .PC_W(PC_W), .OFF_W(OFF_W), .STK_D(STK_D), .RST_VEC(RST_VEC)
  ) dut (
    .clk(clk), .reset(reset), .pc_hold(pc_hold),
    .pc_inc(pc_inc), .pc_ld(pc_ld), .pc_rel(pc_rel),
    .pc_call(pc_call), .pc_ret(pc_ret),
    .pc_in(pc_in), .pc_off(pc_off),
    .pc_out(pc_out), .stk_empty(stk_empty), .stk_full(stk_full),
    .cmd_err(cmd_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] pc;
    logic        empty;
    logic        full;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_txn = 0;

  // Reference model state
  int          m_pc;
  logic [15:0] m_stk[$];
  logic        m_err;

  // Monitor: compare one expected record per clock
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_txn++;
      $display("txn %0d: pc_out=%h empty=%b full=%b err=%b (exp %h %b %b %b)",
               n_txn, pc_out, stk_empty, stk_full, cmd_err,
               e.pc, e.empty, e.full, e.err);
      n_cmp++;
      if (pc_out !== e.pc) begin
        n_bad++;
        $display("FAIL pc_out txn %0d: got %h want %h", n_txn, pc_out, e.pc);
      end
      n_cmp++;
      if (stk_empty !== e.empty) begin
        n_bad++;
        $display("FAIL stk_empty txn %0d: got %b want %b", n_txn, stk_empty, e.empty);
      end
      n_cmp++;
      if (stk_full !== e.full) begin
        n_bad++;
        $display("FAIL stk_full txn %0d: got %b want %b", n_txn, stk_full, e.full);
      end
      n_cmp++;
      if (cmd_err !== e.err) begin
        n_bad++;
        $display("FAIL cmd_err txn %0d: got %b want %b", n_txn, cmd_err, e.err);
      end
    end
  end

  // Apply one cycle of stimulus and advance the reference model.
  // After the clock edge, queue the expected outputs.
  task automatic step(input logic rst_n, input logic hold, input logic [4:0] cmd,
                      input logic [15:0] din, input logic [7:0] off);
    exp_t e;
    int   nbits;
    reset   = rst_n;
    pc_hold = hold;
    {pc_inc, pc_ld, pc_rel, pc_call, pc_ret} = cmd;
    pc_in   = din;
    pc_off  = off;

    nbits = $countones(cmd);
    if (!rst_n) begin
      m_pc = int'(RST_VEC);
      m_stk.delete();
      m_err = 1'b0;
    end else if (hold || nbits == 0) begin
      // nothing changes
    end else if (nbits > 1) begin
`ifdef PC_STK_ERR_EN
      m_err = 1'b1;
`endif
    end else if (cmd == C_INC) begin
      m_pc = (m_pc + 1) % 65536;
    end else if (cmd == C_LD) begin
      m_pc = int'(din);
    end else if (cmd == C_REL) begin
      m_pc = (m_pc + int'($signed(off)) + 65536) % 65536;
    end else if (cmd == C_CALL) begin
      if (m_stk.size() == STK_D) begin
`ifdef PC_STK_ERR_EN
        m_err = 1'b1;
`endif
      end else begin
        m_stk.push_back(16'((m_pc + 1) % 65536));
        m_pc = int'(din);
      end
    end else begin
      if (m_stk.size() == 0) begin
`ifdef PC_STK_ERR_EN
        m_err = 1'b1;
`endif
      end else begin
        m_pc = int'(m_stk.pop_back());
      end
    end

    @(posedge clk);
    #1;
    e.pc    = 16'(m_pc);
    e.empty = (m_stk.size() == 0);
    e.full  = (m_stk.size() == STK_D);
    e.err   = m_err;
    exp_q.push_back(e);
  endtask

  task automatic op(input logic [4:0] cmd, input logic [15:0] din, input logic [7:0] off);
    step(1'b1, 1'b0, cmd, din, off);
  endtask

  logic [4:0] rcmd;
  int         k;

  initial begin
    m_pc  = 0;
    m_err = 1'b0;
    reset = 1'b0; pc_hold = 1'b0;
    {pc_inc, pc_ld, pc_rel, pc_call, pc_ret} = C_NONE;
    pc_in = '0; pc_off = '0;
    @(negedge clk);

    // Reset, increments, hold overriding inc
    step(1'b0, 1'b0, C_NONE, 16'h0, 8'h0);
    for (int i = 0; i < 3; i++) op(C_INC, 16'h0, 8'h0);
    for (int i = 0; i < 2; i++) step(1'b1, 1'b1, C_INC, 16'h0, 8'h0);

    // Wrap and relative branches
    op(C_LD, 16'hFFFF, 8'h0);
    op(C_INC, 16'h0, 8'h0);
    op(C_LD, 16'h0010, 8'h0);
    op(C_REL, 16'h0, 8'hF0);
    op(C_REL, 16'h0, 8'h7F);

    // Call/return nesting
    op(C_LD, 16'h0200, 8'h0);
    op(C_CALL, 16'h0300, 8'h0);
    op(C_CALL, 16'h0400, 8'h0);
    op(C_RET, 16'h0, 8'h0);
    op(C_RET, 16'h0, 8'h0);

    // Overflow and underflow
    for (int i = 0; i < 4; i++) op(C_CALL, 16'h1000 + 16'(i * 16), 8'h0);
    op(C_CALL, 16'h0ABC, 8'h0);
    for (int i = 0; i < 4; i++) op(C_RET, 16'h0, 8'h0);
    op(C_RET, 16'h0, 8'h0);

    // Conflicting commands after a fresh reset
    step(1'b0, 1'b0, C_NONE, 16'h0, 8'h0);
    op(C_LD | C_INC, 16'h5555, 8'h0);

    // Reset in the middle of nested calls
    op(C_CALL, 16'h0700, 8'h0);
    op(C_CALL, 16'h0800, 8'h0);
    step(1'b0, 1'b0, C_CALL, 16'h0900, 8'h0);
    op(C_RET, 16'h0, 8'h0);

    // Randomized traffic, biased towards stack activity
    for (int i = 0; i < 1500; i++) begin
      k = $urandom_range(0, 99);
      if (k < 5) rcmd = C_NONE;
      else if (k < 12) begin
        rcmd = 5'($urandom);
        while ($countones(rcmd) < 2) rcmd = 5'($urandom);
      end
      else if (k < 40) rcmd = C_CALL;
      else if (k < 68) rcmd = C_RET;
      else if (k < 80) rcmd = C_INC;
      else if (k < 90) rcmd = C_LD;
      else rcmd = C_REL;
      step(($urandom_range(0, 99) >= 2), ($urandom_range(0, 99) < 10), rcmd,
           16'($urandom), 8'($urandom));
    end

    // Let the monitor drain, with a bounded wait
    for (int i = 0; i < 4 && exp_q.size() != 0; i++) @(negedge clk);
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pc_stack_unit.md
Name: pc_stack_unit

Overview:
- Parametrised program counter, successor to the lab PC register.
- Adds PC-relative branch, call/return with an internal return-address stack, a global hold (stall), a configurable reset vector and command-conflict detection.
- Sits between the control unit (command strobes) and the IDP/memory address path.
- pc_out drives the memory address bus; pc_in carries the ALU-computed target.

Parameters:
- PC_W, 16, PC / address width in bits.
- OFF_W, 8, width of the signed relative-branch offset (OFF_W <= PC_W).
- STK_D, 4, return-stack depth in entries (power of 2, >= 2).
- RST_VEC, 0, value loaded into pc_out on reset (PC_W bits).

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-low reset, sampled on rising clk.
- pc_hold  in  1  stall; when 1, no state changes (overrides all commands).
- pc_inc  in  1  increment command.
- pc_ld  in  1  absolute load command.
- pc_rel  in  1  relative branch command.
- pc_call  in  1  call command (push return address, jump).
- pc_ret  in  1  return command (pop into PC).
- pc_in  in  PC_W  absolute target (ALU output) for ld/call.
- pc_off  in  OFF_W  signed two's-complement offset for rel.
- pc_out  out  PC_W  current PC.
- stk_empty  out  1  stack holds 0 entries.
- stk_full  out  1  stack holds STK_D entries.
- cmd_err  out  1  sticky; set on an illegal or ignored command.

Behaviour:
- Reset (reset==0 at a rising edge): pc_out=RST_VEC, stack count=0, stk_empty=1, stk_full=0, cmd_err=0. Reset wins over pc_hold and every command; stack contents become don't-care.
- pc_hold==1: all registers hold, including cmd_err; commands are ignored and not flagged.
- Command vector {pc_inc,pc_ld,pc_rel,pc_call,pc_ret}:
  - all zero: hold.
  - more than one bit set: hold and set cmd_err.
- Exactly one command bit set, with the result visible on pc_out one cycle later:
  - inc: pc_out <= pc_out+1, modulo 2^PC_W (all-ones wraps to 0).
  - ld: pc_out <= pc_in.
  - rel: pc_out <= pc_out + sign_extend(pc_off), modulo 2^PC_W; wraps both directions.
  - call, not full: push (pc_out+1 mod 2^PC_W), then pc_out <= pc_in, count+1.
  - call, full: no push, pc_out holds, set cmd_err.
  - ret, not empty: pc_out <= top entry, count-1.
  - ret, empty: pc_out holds, set cmd_err.
- Stack:
  - LIFO, register-array implementation.
  - Top entry is combinationally available internally; a push followed next cycle by a ret returns the pushed value.
- Flags are registered from the count and update in the same cycle as pc_out:
  - stk_full == (count==STK_D).
  - stk_empty == (count==0).
- cmd_err clears only on reset.
- Outputs are registered only; no combinational path from inputs to outputs.

Optional Feature:
- Macro: PC_STK_ERR_EN.
- Defined: behaviour exactly as above; cmd_err is sticky and flags conflicts, overflow and underflow.
- Not defined:
  - cmd_err is tied to 0 and its flop is removed.
  - Overflow/underflow and conflicting commands are still ignored (PC and stack hold), but silently.
  - All other behaviour is unchanged.

Test Plan:
All scenarios use PC_W=16, OFF_W=8, STK_D=4, RST_VEC=16'h0100.
- Reset then inc: reset=0 for 1 clk -> pc_out=0100, stk_empty=1. Then 3 inc cycles -> 0101, 0102, 0103. Set pc_hold=1 with inc=1 for 2 clks -> stays 0103.
- Wrap and relative:
  - ld pc_in=FFFF, then inc -> 0000.
  - ld 0010, then rel pc_off=8'hF0 (-16) -> 0000.
  - rel pc_off=8'h7F -> 007F.
- Call/return nesting:
  - ld 0200, then call pc_in=0300 -> pc_out=0300, stack top=0201, stk_empty=0.
  - call 0400 -> 0400.
  - ret -> 0301; ret -> 0201, stk_empty=1.
- Overflow/underflow:
  - 4 calls -> stk_full=1.
  - 5th call pc_in=0ABC -> pc_out unchanged, cmd_err=1.
  - 4 rets -> stk_empty=1; 5th ret -> pc_out unchanged, cmd_err stays 1.
- Conflict: pc_ld=1 and pc_inc=1 together -> pc_out holds, cmd_err=1. Without PC_STK_ERR_EN -> pc_out holds, cmd_err=0.
- Reset mid-operation: after 2 calls, assert reset with pc_call=1 -> pc_out=0100, stk_empty=1, stk_full=0, cmd_err=0. Subsequent ret -> underflow handling, pc_out stays 0100.
